// File: rtl/arm_seq_ctrl_if.sv
// RAM port between the sequencer (master) and the single-port instruction/data RAM (slave).
// The request is held until ack; read data is valid in the ack cycle.
interface arm_seq_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/arm_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: 4 cycles per ALU op, 5 per load/store, +1 per RAM wait; stalls on missing ack, traps after MEM_TIMEOUT.
// SEQ_CTRL_PERF_EN adds cycle/retired/skipped counters.
module arm_seq_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int MEM_TIMEOUT = 15,
  parameter int RESET_PC    = 0
) (
  input  logic               clk,
  input  logic               i_reset,
  arm_seq_ctrl_if.master     mem,
  output logic [31:0]        o_ins,
  output logic [31:0]        o_ld_data,
  input  logic               i_cond_pass,
  input  logic [1:0]         i_ins_t,
  input  logic               i_br,
  input  logic               i_mem_r_en,
  input  logic               i_mem_w_en,
  input  logic               i_wb_en,
  input  logic               i_s_bit,
  input  logic [31:0]        i_alu_res,
  input  logic [31:0]        i_br_addr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_dec_en,
  output logic               o_ex_en,
  output logic               o_rf_we,
  output logic               o_flags_we,
  output logic               o_wb_sel_mem,
  output logic               o_trap,
  output logic [2:0]         o_state
`ifdef SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]        o_cycles,
  output logic [31:0]        o_retired,
  output logic [31:0]        o_skipped
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             armed;
  logic             req;
  logic             timed_out;
  logic             unused_addr_bits;

  // The first FETCH cycle after reset keeps req low, so a stale ack from a dropped access is ignored.
  assign req       = ((state == S_FETCH) && armed) || (state == S_MEM);
  assign timed_out = (wait_cnt == CNT_W'(MEM_TIMEOUT));

  assign mem.mem_req  = req;
  assign mem.mem_we   = (state == S_MEM) && i_mem_w_en;
  assign mem.mem_addr = (state == S_MEM) ? i_alu_res[ADDR_W+1:2] : o_pc;

  assign o_dec_en     = (state == S_DECODE);
  assign o_ex_en      = (state == S_EXEC);
  assign o_flags_we   = (state == S_EXEC) && i_s_bit && (i_ins_t == 2'b00);
  assign o_rf_we      = (state == S_WB) && i_wb_en && i_cond_pass;
  assign o_wb_sel_mem = (state == S_WB) && i_mem_r_en;
  assign o_trap       = (state == S_TRAP);
  assign o_state      = state;

  assign unused_addr_bits = ^{i_alu_res[31:ADDR_W+2], i_alu_res[1:0],
                              i_br_addr[31:ADDR_W+2], i_br_addr[1:0]};

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= S_FETCH;
      o_pc      <= ADDR_W'(RESET_PC);
      o_ins     <= '0;
      o_ld_data <= '0;
      wait_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      armed    <= 1'b1;
      // Cleared on every cycle that does not extend a RAM wait, so each access starts at zero.
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (req) begin
            if (mem.mem_ack) begin
              o_ins <= mem.mem_rdata;
              state <= S_DECODE;
            end else if (timed_out) begin
              state <= S_TRAP;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
        end
        S_DECODE: begin
          if (!i_cond_pass)             state <= S_WB;
          else if (i_ins_t == 2'b11)    state <= S_TRAP;
          else                          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= (i_mem_r_en || i_mem_w_en) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem.mem_ack) begin
            if (i_mem_r_en) o_ld_data <= mem.mem_rdata;
            state <= S_WB;
          end else if (timed_out) begin
            state <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          if (i_br && i_cond_pass) o_pc <= i_br_addr[ADDR_W+1:2];
          else                     o_pc <= o_pc + ADDR_W'(1);
          state <= S_FETCH;
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

`ifdef SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_cycles  <= '0;
      o_retired <= '0;
      o_skipped <= '0;
    end else begin
      o_cycles <= o_cycles + 32'd1;
      if (state == S_WB) begin
        if (i_cond_pass) o_retired <= o_retired + 32'd1;
        else             o_skipped <= o_skipped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// Bench for arm_seq_ctrl: instruction table, randomized instructions vs a latency/PC model, trap and reset corners.
module tb_arm_seq_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset;
  logic [31:0]   o_ins, o_ld_data;
  logic          i_cond_pass;
  logic [1:0]    i_ins_t;
  logic          i_br, i_mem_r_en, i_mem_w_en, i_wb_en, i_s_bit;
  logic [31:0]   i_alu_res, i_br_addr;
  logic [AW-1:0] o_pc;
  logic          o_dec_en, o_ex_en, o_rf_we, o_flags_we, o_wb_sel_mem, o_trap;
  logic [2:0]    o_state;
`ifdef SEQ_CTRL_PERF_EN
  logic [31:0]   o_cycles, o_retired, o_skipped;
`endif

  arm_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  arm_seq_ctrl #(.ADDR_W(AW), .MEM_TIMEOUT(15), .RESET_PC(0)) dut (
    .clk(clk), .i_reset(i_reset), .mem(bus),
    .o_ins(o_ins), .o_ld_data(o_ld_data),
    .i_cond_pass(i_cond_pass), .i_ins_t(i_ins_t), .i_br(i_br),
    .i_mem_r_en(i_mem_r_en), .i_mem_w_en(i_mem_w_en), .i_wb_en(i_wb_en),
    .i_s_bit(i_s_bit), .i_alu_res(i_alu_res), .i_br_addr(i_br_addr),
    .o_pc(o_pc), .o_dec_en(o_dec_en), .o_ex_en(o_ex_en), .o_rf_we(o_rf_we),
    .o_flags_we(o_flags_we), .o_wb_sel_mem(o_wb_sel_mem), .o_trap(o_trap),
    .o_state(o_state)
`ifdef SEQ_CTRL_PERF_EN
    , .o_cycles(o_cycles), .o_retired(o_retired), .o_skipped(o_skipped)
`endif
  );

  typedef struct {
    logic [31:0] ins;
    logic        cond;
    logic [1:0]  t;
    logic        br, rd, wr, wb, s;
    logic [31:0] alu, bra, ld;
    int          fd, md;          // RAM wait cycles for fetch / data access
    int          ecyc;            // expected cycles from first fetch request through WB
    logic        eex, erf, efl;
    logic [AW-1:0] epc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_pc;
  logic [31:0]   exp_ld;
  int obs_cyc, obs_dec, obs_ex, obs_rf, obs_fl, obs_memreq, obs_bad;
  logic obs_sel, obs_trap, obs_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    exp_pc = '0;
    exp_ld = '0;
  endtask

  // Latency and PC outcome derived directly from the instruction's attributes.
  function automatic vec_t model(input vec_t v, input logic [AW-1:0] pc);
    logic mem_op;
    mem_op = v.rd | v.wr;
    v.ecyc = v.fd + (v.cond ? (4 + (mem_op ? 1 + v.md : 0)) : 3);
    v.eex  = v.cond;
    v.erf  = v.cond & v.wb;
    v.efl  = v.cond & v.s & (v.t == 2'b00);
    v.epc  = (v.cond & v.br) ? v.bra[AW+1:2] : pc + AW'(1);
    return v;
  endfunction

  // Plays the RAM and the decoder for one instruction; entered and left #1-#2 after a rising edge.
  task automatic run_instr(input vec_t v, input logic [AW-1:0] pc0);
    int   phase = 0;
    int   wait_n = 0;
    int   dly;
    logic prev_req = 1'b0;
    i_cond_pass = v.cond; i_ins_t = v.t; i_br = v.br; i_mem_r_en = v.rd;
    i_mem_w_en = v.wr; i_wb_en = v.wb; i_s_bit = v.s; i_alu_res = v.alu; i_br_addr = v.bra;
    obs_cyc = 0; obs_dec = 0; obs_ex = 0; obs_rf = 0; obs_fl = 0; obs_memreq = 0; obs_bad = 0;
    obs_sel = 1'b0; obs_trap = 1'b0; obs_done = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (bus.mem_req) begin
        if (!prev_req) phase++;
        dly = (phase == 1) ? v.fd : v.md;
        if (wait_n >= dly) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = (phase == 1) ? v.ins : v.ld;
          wait_n = 0;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = $urandom;
          wait_n++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
      end
      prev_req = bus.mem_req;
      #1;
      if (phase > 0) obs_cyc++;
      obs_dec += int'(o_dec_en);
      obs_ex  += int'(o_ex_en);
      obs_rf  += int'(o_rf_we);
      obs_fl  += int'(o_flags_we);
      if (bus.mem_req && phase == 1 && (bus.mem_addr !== pc0 || bus.mem_we !== 1'b0)) obs_bad++;
      if (bus.mem_req && phase == 2) begin
        obs_memreq++;
        if (bus.mem_addr !== v.alu[AW+1:2] || bus.mem_we !== v.wr) obs_bad++;
      end
      if (int'(o_dec_en) + int'(o_ex_en) + int'(o_rf_we) + int'(bus.mem_req) > 1) obs_bad++;
      if (o_state == 3'd4) begin
        obs_sel = o_wb_sel_mem;
        obs_done = 1'b1;
        break;
      end
      if (o_trap) begin
        obs_trap = 1'b1;
        obs_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic check_instr(input vec_t v, input string tag);
    run_instr(v, exp_pc);
    chk({tag, "_done"},  32'(obs_done), 32'd1);
    chk({tag, "_cyc"},   obs_cyc, v.ecyc);
    chk({tag, "_dec"},   obs_dec, 1);
    chk({tag, "_ex"},    obs_ex, 32'(v.eex));
    chk({tag, "_rf_we"}, obs_rf, 32'(v.erf));
    chk({tag, "_flags"}, obs_fl, 32'(v.efl));
    chk({tag, "_sel"},   32'(obs_sel), 32'(v.rd));
    chk({tag, "_bus"},   obs_bad, 0);
    if (v.cond && v.rd) exp_ld = v.ld;
    exp_pc = v.epc;
    @(posedge clk); #1;
    chk({tag, "_pc"},    32'(o_pc), 32'(exp_pc));
    chk({tag, "_state"}, 32'(o_state), 32'd0);
    chk({tag, "_ins"},   o_ins, v.ins);
    chk({tag, "_ld"},    o_ld_data, exp_ld);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    int n_ret, n_skip;

    i_cond_pass = 0; i_ins_t = 0; i_br = 0; i_mem_r_en = 0; i_mem_w_en = 0;
    i_wb_en = 0; i_s_bit = 0; i_alu_res = 0; i_br_addr = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;

    //        ins           cnd t     br rd wr wb s  alu       bra       ld            fd md  cyc ex rf fl pc
    tbl[0] = '{32'hE2821001, 1, 2'b00, 0, 0, 0, 1, 0, 32'h0,    32'h0,    32'h0,        0, 0,  4, 1, 1, 0, 10'h001};
    tbl[1] = '{32'hE5910000, 1, 2'b01, 0, 1, 0, 1, 0, 32'h10,   32'h0,    32'hCAFEF00D, 0, 2,  7, 1, 1, 0, 10'h002};
    tbl[2] = '{32'h1A000003, 0, 2'b10, 1, 0, 0, 0, 0, 32'h0,    32'h40,   32'h0,        0, 0,  3, 0, 0, 0, 10'h003};
    tbl[3] = '{32'h1A000003, 1, 2'b10, 1, 0, 0, 0, 0, 32'h0,    32'h40,   32'h0,        0, 0,  4, 1, 0, 0, 10'h010};
    tbl[4] = '{32'hE3510000, 1, 2'b00, 0, 0, 0, 0, 1, 32'h0,    32'h0,    32'h0,        1, 0,  5, 1, 0, 1, 10'h011};
    tbl[5] = '{32'hE5810000, 1, 2'b01, 0, 0, 1, 0, 0, 32'hFFC,  32'h0,    32'h0,        0, 1,  6, 1, 0, 0, 10'h012};
    tbl[6] = '{32'hEA000000, 1, 2'b10, 1, 0, 0, 0, 0, 32'h0,    32'hFFC,  32'h0,        0, 0,  4, 1, 0, 0, 10'h3FF};
    tbl[7] = '{32'hE2911001, 1, 2'b00, 0, 0, 0, 1, 1, 32'h0,    32'h0,    32'h0,        0, 0,  4, 1, 1, 1, 10'h000};
    tbl[8] = '{32'h05910000, 0, 2'b01, 0, 1, 0, 1, 0, 32'h20,   32'h0,    32'h12345678, 2, 0,  5, 0, 0, 0, 10'h001};

    do_reset();
    chk("rst_pc",    32'(o_pc), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_req",   32'(bus.mem_req), 32'd0);
    chk("rst_trap",  32'(o_trap), 32'd0);
    chk("rst_strobes", {28'd0, o_dec_en, o_ex_en, o_rf_we, o_flags_we}, 32'd0);
    chk("rst_sel",   32'(o_wb_sel_mem), 32'd0);
    chk("rst_ins",   o_ins, 32'd0);
    chk("rst_ld",    o_ld_data, 32'd0);

    n_ret = 0; n_skip = 0;
    for (int i = 0; i < 9; i++) begin
      check_instr(tbl[i], $sformatf("row%0d", i));
      if (tbl[i].cond) n_ret++; else n_skip++;
    end
`ifdef SEQ_CTRL_PERF_EN
    chk("perf_retired", o_retired, 32'(n_ret));
    chk("perf_skipped", o_skipped, 32'(n_skip));
`endif

    for (int i = 0; i < 40; i++) begin
      v.ins = $urandom;
      v.t    = 2'($urandom_range(0, 3));
      v.cond = 1'($urandom_range(0, 3) != 0);
      if (v.t == 2'b11) v.cond = 1'b0;
      v.br = 1'($urandom_range(0, 1));
      v.rd = 1'b0; v.wr = 1'b0;
      case ($urandom_range(0, 2))
        1: v.rd = 1'b1;
        2: v.wr = 1'b1;
        default: ;
      endcase
      v.wb = 1'($urandom_range(0, 1));
      v.s  = 1'($urandom_range(0, 1));
      v.alu = $urandom; v.bra = $urandom; v.ld = $urandom;
      v.fd = $urandom_range(0, 3); v.md = $urandom_range(0, 3);
      v = model(v, exp_pc);
      check_instr(v, $sformatf("rnd%0d", i));
    end

    // Data access never acknowledged: trap after MEM_TIMEOUT+1 request cycles, then sticky.
    do_reset();
    v = tbl[1];
    v.md = 100;
    run_instr(v, exp_pc);
    chk("to_trap",   32'(obs_trap), 32'd1);
    chk("to_memreq", obs_memreq, 16);
    chk("to_req_drop", 32'(bus.mem_req), 32'd0);
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    chk("to_sticky", 32'(o_trap), 32'd1);
    chk("to_state",  32'(o_state), 32'd7);
    chk("to_pc",     32'(o_pc), 32'd0);
    do_reset();
    chk("to_rst_trap",  32'(o_trap), 32'd0);
    chk("to_rst_state", 32'(o_state), 32'd0);
    chk("to_rst_pc",    32'(o_pc), 32'd0);

    // Coprocessor instruction traps out of DECODE without an execute strobe.
    v = tbl[0];
    v.t = 2'b11;
    run_instr(v, exp_pc);
    chk("cp_trap", 32'(obs_trap), 32'd1);
    chk("cp_ex",   obs_ex, 0);
    chk("cp_pc",   32'(o_pc), 32'd0);

    // Reset while a data access is outstanding; a late ack must not be taken as a fetch.
    do_reset();
    v = tbl[1];
    i_cond_pass = 1; i_ins_t = v.t; i_br = 0; i_mem_r_en = 1; i_mem_w_en = 0;
    i_wb_en = 1; i_s_bit = 0; i_alu_res = v.alu;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = v.ins;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    chk("mr_req_before", 32'(bus.mem_req), 32'd1);
    chk("mr_state_before", 32'(o_state), 32'd3);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    chk("mr_req",   32'(bus.mem_req), 32'd0);
    chk("mr_state", 32'(o_state), 32'd0);
    chk("mr_ins",   o_ins, 32'd0);
`ifdef SEQ_CTRL_PERF_EN
    chk("mr_cycles",  o_cycles, 32'd0);
    chk("mr_retired", o_retired, 32'd0);
    chk("mr_skipped", o_skipped, 32'd0);
`endif
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("late_ack_state", 32'(o_state), 32'd0);
    chk("late_ack_ins",   o_ins, 32'd0);
    chk("late_ack_req",   32'(bus.mem_req), 32'd1);
`ifdef SEQ_CTRL_PERF_EN
    chk("perf_cycles_1", o_cycles, 32'd1);
`endif
    exp_pc = '0; exp_ld = '0;
    check_instr(model(tbl[0], exp_pc), "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
